// File: rtl/skolem_chk_pkg.sv
// Shared types, constants and the constraint predicate for the Skolem witness checker.
package skolem_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMPARE,
    ST_SWEEP,
    ST_DONE
  } state_t;

  localparam int BV_W      = 4;
  localparam int MAX_SHIFT = 4;

  // (x >>u s) <=s t; shift amounts of BV_W or more clear the value.
  function automatic logic lshr_le_s(input logic [BV_W-1:0] xv,
                                     input logic [BV_W-1:0] sv,
                                     input logic [BV_W-1:0] tv);
    logic [BV_W-1:0] shv;
    shv = xv >> sv;
    return $signed(shv) <= $signed(tv);
  endfunction

endpackage

// File: rtl/skolem_witness_checker_sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc until the counter reaches its maximum value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/skolem_witness_checker.sv
// Sequential checker for the 4-bit find_inv_bvsle_bvlshr0 Skolem witness.
// Optional exhaustive satisfiability sweep: define SKOLEM_CHK_SWEEP_EN.
module skolem_witness_checker
  import skolem_chk_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BV_W-1:0]  s,
  input  logic [BV_W-1:0]  t,
  input  logic [BV_W-1:0]  x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ok,
  output logic             exists,
  output logic             mismatch,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  state_t state, state_nx;

  logic [2:0]      k;
  logic [BV_W-1:0] sh;
  logic [BV_W-1:0] t_q;
  logic            ok_q;
  logic            deliver;

`ifdef SKOLEM_CHK_SWEEP_EN
  logic [BV_W-1:0] s_q;
  logic [BV_W-1:0] cand;
  logic            exists_q;
`endif

  // State register; reset abandons any in-flight triple.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = (s == '0) ? ST_COMPARE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (k == 3'd1) state_nx = ST_COMPARE;
      end
      ST_COMPARE: begin
`ifdef SKOLEM_CHK_SWEEP_EN
        state_nx = ST_SWEEP;
`else
        state_nx = ST_DONE;
`endif
      end
`ifdef SKOLEM_CHK_SWEEP_EN
      ST_SWEEP: begin
        if (cand == {BV_W{1'b1}}) state_nx = ST_DONE;
      end
`endif
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand capture and serial shift; data registers need no reset.
  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          sh  <= x;
          t_q <= t;
          k   <= (s >= BV_W'(MAX_SHIFT)) ? 3'(MAX_SHIFT) : s[2:0];
`ifdef SKOLEM_CHK_SWEEP_EN
          s_q <= s;
`endif
        end
      end
      ST_SHIFT: begin
        sh <= {1'b0, sh[BV_W-1:1]};
        k  <= k - 3'd1;
      end
`ifdef SKOLEM_CHK_SWEEP_EN
      ST_COMPARE: cand <= '0;
      ST_SWEEP:   cand <= cand + {{(BV_W-1){1'b0}}, 1'b1};
`endif
      default: ;
    endcase
  end

  // Verdict registers; held through DONE until the consumer takes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      ok_q <= 1'b0;
`ifdef SKOLEM_CHK_SWEEP_EN
      exists_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_COMPARE: begin
          ok_q <= ($signed(sh) <= $signed(t_q));
`ifdef SKOLEM_CHK_SWEEP_EN
          exists_q <= 1'b0;
`endif
        end
`ifdef SKOLEM_CHK_SWEEP_EN
        ST_SWEEP: exists_q <= exists_q | lshr_le_s(cand, s_q, t_q);
`endif
        default: ;
      endcase
    end
  end

  assign ok = ok_q;
`ifdef SKOLEM_CHK_SWEEP_EN
  assign exists   = exists_q;
  assign mismatch = exists_q & ~ok_q;
`else
  assign exists   = ok_q;
  assign mismatch = 1'b0;
`endif

  assign deliver = (state == ST_DONE) & out_ready;

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk (clk),
    .rst (rst),
    .inc (deliver & ok_q),
    .cnt (pass_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk (clk),
    .rst (rst),
    .inc (deliver & ~ok_q),
    .cnt (fail_cnt)
  );

endmodule

// File: tb/tb_skolem_witness_checker.sv
// Directed self-checking bench for skolem_witness_checker.
module tb_skolem_witness_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] s, t, x;
  logic       out_valid;
  logic       out_ready;
  logic       ok, exists, mismatch;
  logic [7:0] pass_cnt, fail_cnt;

  int checks = 0;
  int passed = 0;

`ifdef SKOLEM_CHK_SWEEP_EN
  localparam int SW = 16;
  localparam bit MAC = 1'b1;
`else
  localparam int SW = 0;
  localparam bit MAC = 1'b0;
`endif

  skolem_witness_checker #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .t         (t),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ok        (ok),
    .exists    (exists),
    .mismatch  (mismatch),
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present a triple for one edge (caller ensures in_ready is high).
  task automatic send(input logic [3:0] si, input logic [3:0] ti, input logic [3:0] xi);
    in_valid = 1'b1; s = si; t = ti; x = xi;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid; returns the cycle index relative to the accept cycle T.
  task automatic wait_out(output int cyc);
    int n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    cyc = n + 1;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [3:0] si, input logic [3:0] ti,
                     input logic [3:0] xi, input int lat_exp, input logic ok_e,
                     input logic ex_e, input logic mm_e);
    int cyc;
    chk({tag, "_in_ready"}, in_ready, 1);
    send(si, ti, xi);
    wait_out(cyc);
    chk({tag, "_latency"}, cyc, lat_exp);
    chk({tag, "_ok"}, ok, ok_e);
    chk({tag, "_exists"}, exists, ex_e);
    chk({tag, "_mismatch"}, mismatch, mm_e);
  endtask

  initial begin
    int cyc;
    bit stable, ever_valid;
    logic ok_s, ex_s, mm_s;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; s = '0; t = '0; x = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ok", ok, 0);
    chk("rst_exists", exists, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_fail_cnt", fail_cnt, 0);

    // s=0 t=0 x=0: 0 <=s 0
    run("t1", 4'd0, 4'd0, 4'd0, 2 + SW, 1'b1, 1'b1, 1'b0);
    take();
    chk("t1_pass_cnt", pass_cnt, 1);
    chk("t1_fail_cnt", fail_cnt, 0);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_out_valid_low", out_valid, 0);

    // s=0 t=0 x=1: generator missed x=0
    run("t2", 4'd0, 4'd0, 4'd1, 2 + SW, 1'b0, MAC, MAC);
    take();
    chk("t2_fail_cnt", fail_cnt, 1);
    chk("t2_pass_cnt", pass_cnt, 1);

    // s=1 t=-8 x=5: every shifted value is non-negative, unsatisfiable
    run("t3", 4'd1, 4'b1000, 4'd5, 3 + SW, 1'b0, 1'b0, 1'b0);
    take();
    chk("t3_fail_cnt", fail_cnt, 2);

    // s=5 t=0 x=15: shift clamps to 4, sh=0
    run("t4", 4'd5, 4'd0, 4'd15, 6 + SW, 1'b1, 1'b1, 1'b0);
    take();
    chk("t4_pass_cnt", pass_cnt, 2);

    // Backpressure: s=2 t=3 x=12 -> 3 <=s 3
    run("t5", 4'd2, 4'd3, 4'd12, 4 + SW, 1'b1, 1'b1, 1'b0);
    ok_s = ok; ex_s = exists; mm_s = mismatch;
    stable = 1'b1;
    in_valid = 1'b1; s = 4'd0; t = 4'd0; x = 4'd1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || ok !== ok_s || exists !== ex_s || mismatch !== mm_s ||
          pass_cnt !== 8'd2 || fail_cnt !== 8'd2)
        stable = 1'b0;
    end
    in_valid = 1'b0;
    chk("bp_stable", stable, 1);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_ok", ok, 1);
    take();
    chk("bp_pass_cnt", pass_cnt, 3);
    chk("bp_fail_cnt", fail_cnt, 2);
    chk("bp_in_ready_after", in_ready, 1);
    repeat (3) @(posedge clk);
    #1 chk("bp_no_stray_accept", out_valid, 0);

    // Reset during SHIFT discards the triple
    send(4'd3, 4'd7, 4'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_pass_cnt", pass_cnt, 0);
    chk("abort_fail_cnt", fail_cnt, 0);
    ever_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) ever_valid = 1'b1;
    end
    chk("abort_no_verdict", ever_valid, 0);

    // 256 failing triples saturate fail_cnt
    for (int i = 0; i < 256; i++) begin
      send(4'd0, 4'd0, 4'd1);
      wait_out(cyc);
      take();
      if (i == 254) chk("sat_fail_255", fail_cnt, 255);
      if (i == 0) chk("sat_fail_1", fail_cnt, 1);
    end
    chk("sat_fail_hold", fail_cnt, 255);
    chk("sat_pass_zero", pass_cnt, 0);
    chk("sat_ok", ok, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/skolem_witness_checker.md
# skolem_witness_checker

Sequential checker for the 4-bit `find_inv_bvsle_bvlshr0` Skolem function. It sits downstream of the combinational witness generator and accepts (s, t, x) triples, where x is the generator's witness. For each triple it decides whether the constraint (x >>u s) <=s t holds. It returns the verdict over a valid/ready handshake and keeps running pass/fail statistics.

## Interface
Parameters:
- CNT_W, 8, width of the saturating pass/fail counters.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  triple present.
- in_ready  out  1  checker can accept a triple (high only in IDLE).
- s  in  4  logical-shift amount, unsigned.
- t  in  4  bound, two's-complement signed.
- x  in  4  witness under test.
- out_valid  out  1  verdict present.
- out_ready  in  1  consumer accepts verdict.
- ok  out  1  (x >>u s) <=s t for the supplied x.
- exists  out  1  some 4-bit x satisfies the constraint for this (s, t).
- mismatch  out  1  exists & ~ok: the generator missed a satisfiable instance.
- pass_cnt  out  CNT_W  count of delivered verdicts with ok=1.
- fail_cnt  out  CNT_W  count of delivered verdicts with ok=0.

## Operation
- States: IDLE, SHIFT, COMPARE, SWEEP (macro only), DONE.
- **IDLE:** in_ready=1. On in_valid, capture s, t and x; load shift register sh=x; load k=min(s,4).
  - k=0: go to COMPARE.
  - k>0: go to SHIFT.
- **SHIFT:** sh <= {1'b0, sh[3:1]} each cycle; k decrements. Leave for COMPARE when k reaches 0.
  - s>=4 therefore yields sh=0 after 4 cycles.
- **COMPARE:** ok <= ($signed(sh) <= $signed(t)).
  - sh is zero-extended-shifted, so it is treated as signed 4-bit exactly as stored.
  - Next state is SWEEP if the macro is defined, else DONE.
- **SWEEP:** one candidate c = 0..15 per cycle. exists |= ((c >>u s) <=s t), using a combinational barrel shift.
  - Leave to DONE after c=15.
- **DONE:** out_valid=1. ok, exists and mismatch are held stable until out_ready.
  - On out_valid & out_ready, update counters, then return to IDLE.
- **Counters:** pass_cnt increments when ok=1, fail_cnt when ok=0. Both saturate at 2^CNT_W-1 and never wrap.
- **Reset values:** state=IDLE, in_ready=1, out_valid=0, ok=0, exists=0, mismatch=0, pass_cnt=0, fail_cnt=0.
- **Reset mid-operation:** a reset in any state discards the in-flight triple. No counter update and no verdict are produced.
- **Input handling:** inputs are ignored outside IDLE. in_valid held high while in_ready=0 is not a transfer.

## Timing
- Accept handshake at cycle T.
- k = min(s,4) SHIFT cycles occupy T+1..T+k.
- COMPARE at T+k+1.
- Without the macro: out_valid rises at T+k+2. Latency range is 2..6 cycles.
- With the macro: SWEEP occupies T+k+2..T+k+17 and out_valid rises at T+k+18.
- Throughput: one triple in flight. in_ready rises the cycle after the output handshake.
- Counters reflect a verdict one cycle after its output handshake.

## Configuration
- **SKOLEM_CHK_SWEEP_EN defined:** the SWEEP state is built and exists is computed exhaustively over all 16 candidates. mismatch = exists & ~ok.
- **SKOLEM_CHK_SWEEP_EN undefined:** the SWEEP state and the barrel shifter are omitted. exists is driven equal to ok, so mismatch is constantly 0.

## Structure
- Package `skolem_chk_pkg` holds:
  - the state enum typedef;
  - the constant BV_W=4;
  - the constant MAX_SHIFT=4;
  - the function `lshr_le_s(x,s,t)`, the combinational constraint predicate used by SWEEP and by the bench model.
- One natural sub-module, `sat_counter`, instantiated twice (pass and fail). It is parameterised by width and has inc and rst inputs.

## Test plan
- s=0, t=0, x=0 -> out_valid at T+2; ok=1, mismatch=0; pass_cnt=1.
- s=0, t=0, x=1 -> ok=0.
  - With macro: exists=1 (x=0 witnesses), mismatch=1.
  - Without macro: exists=0, mismatch=0.
  - fail_cnt=1 in both builds.
- s=1, t=4'b1000 (−8), x=5 -> ok=0, exists=0, mismatch=0 in both builds. With macro, out_valid at T+19.
- s=5, t=0, x=15 -> k=4, sh=0, ok=1; out_valid at T+6 without macro.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, ok, exists and mismatch stay stable; in_ready=0; counters unchanged; a new in_valid is not accepted.
- Assert rst during SHIFT, then after reset issue 256 failing triples (s=0, t=0, x=1) -> no verdict for the aborted triple; fail_cnt saturates at 255; pass_cnt=0.
